// File: rtl/icache_line_fill.sv
// I-cache refill engine: fetches a 16-byte line as in-order 32-bit bus beats and returns it with a one-cycle ready pulse.
// Optional one-entry line buffer under ICACHE_FILL_LINEBUF_EN; without it, flush_i is unused.
module icache_line_fill #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 128,
  parameter int unsigned BUS_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              flush_i,
  output logic              ready_o,
  output logic [LINE_W-1:0] data_o,
  output logic              busy_o,
  output logic              bus_req_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  input  logic              bus_ack_i,
  input  logic [BUS_W-1:0]  bus_rdata_i
);

  localparam int unsigned BEATS = LINE_W / BUS_W;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned OFF_W = $clog2(LINE_W / 8);
  localparam int unsigned BSH   = $clog2(BUS_W / 8);
  localparam int unsigned TAG_W = ADDR_W - OFF_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BEAT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [TAG_W-1:0]    req_tag;

  assign req_tag = addr_i[ADDR_W-1:OFF_W];

`ifdef ICACHE_FILL_LINEBUF_EN
  logic             lb_valid_q, lb_valid_d;
  logic [TAG_W-1:0] lb_tag_q, lb_tag_d;
  logic             flush_seen_q, flush_seen_d;
  logic             lb_hit;
  logic [OFF_W-1:0] unused_bits;

  // A flush in the same cycle as the request forces the miss path.
  assign lb_hit      = lb_valid_q && !flush_i && (lb_tag_q == req_tag);
  assign unused_bits = addr_i[OFF_W-1:0];
`else
  logic [OFF_W:0] unused_bits;

  assign unused_bits = {flush_i, addr_i[OFF_W-1:0]};
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    line_d  = line_q;
`ifdef ICACHE_FILL_LINEBUF_EN
    lb_valid_d   = lb_valid_q;
    lb_tag_d     = lb_tag_q;
    flush_seen_d = flush_seen_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          base_d = {req_tag, {OFF_W{1'b0}}};
          cnt_d  = '0;
`ifdef ICACHE_FILL_LINEBUF_EN
          flush_seen_d = 1'b0;
          state_d      = lb_hit ? S_DONE : S_BEAT;
`else
          state_d = S_BEAT;
`endif
        end
      end
      S_BEAT: begin
        if (bus_ack_i) begin
          line_d[int'(cnt_q)*BUS_W +: BUS_W] = bus_rdata_i;
          if (cnt_q == CNT_W'(BEATS - 1)) begin
            cnt_d   = '0;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
`ifdef ICACHE_FILL_LINEBUF_EN
        // A flush seen at any point of the fill leaves the buffer invalid.
        lb_valid_d = !flush_seen_q;
        lb_tag_d   = base_q[ADDR_W-1:OFF_W];
`endif
      end
      default: state_d = S_IDLE;
    endcase
`ifdef ICACHE_FILL_LINEBUF_EN
    if (flush_i) begin
      lb_valid_d = 1'b0;
      if (state_q != S_IDLE) flush_seen_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      line_q  <= line_d;
    end
  end

`ifdef ICACHE_FILL_LINEBUF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lb_valid_q   <= 1'b0;
      lb_tag_q     <= '0;
      flush_seen_q <= 1'b0;
    end else begin
      lb_valid_q   <= lb_valid_d;
      lb_tag_q     <= lb_tag_d;
      flush_seen_q <= flush_seen_d;
    end
  end
`endif

  // Outputs decode the registered state only, so they hold steady through bus stalls.
  assign ready_o    = (state_q == S_DONE);
  assign busy_o     = (state_q != S_IDLE);
  assign bus_req_o  = (state_q == S_BEAT);
  assign bus_addr_o = (state_q == S_BEAT) ? (base_q + (ADDR_W'(cnt_q) << BSH)) : '0;
  assign data_o     = line_q;

endmodule
